pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use stall, data-memory wait freeze.
// Optional saturating stall counter output enabled by PIPE_HAZARD_STALL_CNT_EN.
module pipe_hazard_ctrl (
  input  logic       clock,
  input  logic       resetn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_wreg,
  input  logic       id_m2reg,
  input  logic       id_mem,
  input  logic [4:0] id_rn,
  input  logic       id_branch,
  input  logic       mem_ready,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       wpcir,
  output logic       bubble,
  output logic       flush_if,
  output logic       freeze,
  output logic [1:0] state
`ifdef PIPE_HAZARD_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int unsigned RW = 5;
  localparam int unsigned SW = 2;

  localparam logic [SW-1:0] ST_RUN     = 2'b00;
  localparam logic [SW-1:0] ST_LDSTALL = 2'b01;
  localparam logic [SW-1:0] ST_MEMWAIT = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MMA = 2'b10;
  localparam logic [1:0] FWD_MML = 2'b11;

  logic          ex_wreg_q, ex_m2reg_q, ex_mem_q;
  logic          ex_wreg_d, ex_m2reg_d, ex_mem_d;
  logic [RW-1:0] ex_rn_q, ex_rn_d;
  logic          mm_wreg_q, mm_m2reg_q, mm_mem_q;
  logic          mm_wreg_d, mm_m2reg_d, mm_mem_d;
  logic [RW-1:0] mm_rn_q, mm_rn_d;
  logic [SW-1:0] state_q, state_d;

  logic load_use_c;
  logic memwait_c;

  // Operand source: a non-load result in EX wins over anything in MEM.
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_wreg_q && !ex_m2reg_q && (ex_rn_q != '0) && (ex_rn_q == src))
      sel = FWD_EX;
    else if (mm_wreg_q && (mm_rn_q != '0) && (mm_rn_q == src))
      sel = mm_m2reg_q ? FWD_MML : FWD_MMA;
    return sel;
  endfunction

  always_comb begin
    load_use_c = ex_wreg_q && ex_m2reg_q && (ex_rn_q != '0) &&
                 ((id_use_rs && (ex_rn_q == id_rs)) ||
                  (id_use_rt && (ex_rn_q == id_rt)));
    memwait_c  = mm_mem_q && !mem_ready;
  end

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // Next state: memory wait outranks load-use; the unused code falls back to RUN.
  always_comb begin
    state_d = ST_RUN;
    if (memwait_c)       state_d = ST_MEMWAIT;
    else if (load_use_c) state_d = ST_LDSTALL;
  end

  // Hazard outputs, zero-cycle decision from shadows and current ID inputs
  always_comb begin
    fwda     = fwd_sel(id_rs);
    fwdb     = fwd_sel(id_rt);
    freeze   = memwait_c;
    wpcir    = !load_use_c && !memwait_c;
    bubble   = load_use_c && !memwait_c;
    flush_if = id_branch && !load_use_c && !memwait_c;
    state    = state_q;
  end

  // Shadow pipeline advance; a bubble loads a NOP into EX
  always_comb begin
    ex_wreg_d  = ex_wreg_q;
    ex_m2reg_d = ex_m2reg_q;
    ex_mem_d   = ex_mem_q;
    ex_rn_d    = ex_rn_q;
    mm_wreg_d  = mm_wreg_q;
    mm_m2reg_d = mm_m2reg_q;
    mm_mem_d   = mm_mem_q;
    mm_rn_d    = mm_rn_q;
    if (!freeze) begin
      mm_wreg_d  = ex_wreg_q;
      mm_m2reg_d = ex_m2reg_q;
      mm_mem_d   = ex_mem_q;
      mm_rn_d    = ex_rn_q;
      if (bubble) begin
        ex_wreg_d  = 1'b0;
        ex_m2reg_d = 1'b0;
        ex_mem_d   = 1'b0;
        ex_rn_d    = '0;
      end else begin
        ex_wreg_d  = id_wreg;
        ex_m2reg_d = id_m2reg;
        ex_mem_d   = id_mem;
        ex_rn_d    = id_rn;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ex_wreg_q  <= 1'b0;
      ex_m2reg_q <= 1'b0;
      ex_mem_q   <= 1'b0;
      ex_rn_q    <= '0;
      mm_wreg_q  <= 1'b0;
      mm_m2reg_q <= 1'b0;
      mm_mem_q   <= 1'b0;
      mm_rn_q    <= '0;
    end else begin
      ex_wreg_q  <= ex_wreg_d;
      ex_m2reg_q <= ex_m2reg_d;
      ex_mem_q   <= ex_mem_d;
      ex_rn_q    <= ex_rn_d;
      mm_wreg_q  <= mm_wreg_d;
      mm_m2reg_q <= mm_m2reg_d;
      mm_mem_q   <= mm_mem_d;
      mm_rn_q    <= mm_rn_d;
    end
  end

`ifdef PIPE_HAZARD_STALL_CNT_EN
  localparam int unsigned CW = 16;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  // Count cycles with the front end held, saturating at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!wpcir && (stall_cnt_q != {CW{1'b1}}))
      stall_cnt_d = stall_cnt_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!resetn) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a stage-list model.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic [4:0] id_rs, id_rt, id_rn;
  logic       id_use_rs, id_use_rt, id_wreg, id_m2reg, id_mem, id_branch, mem_ready;
  logic [1:0] fwda, fwdb, state;
  logic       wpcir, bubble, flush_if, freeze;
`ifdef PIPE_HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl dut (
    .clock(clock), .resetn(resetn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_mem(id_mem), .id_rn(id_rn),
    .id_branch(id_branch), .mem_ready(mem_ready),
    .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .bubble(bubble),
    .flush_if(flush_if), .freeze(freeze), .state(state)
`ifdef PIPE_HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       wr;
    bit       ld;
    bit       acc;
    bit [4:0] dst;
  } instr_t;

  // pipe[0] = instruction in EX, pipe[1] = instruction in MEM
  instr_t pipe [2];
  int     m_state;
  int     m_cnt;

  function automatic instr_t nop();
    instr_t n;
    n.wr = 0; n.ld = 0; n.acc = 0; n.dst = 0;
    return n;
  endfunction

  // Youngest writer of src supplies the operand; a load still in EX cannot supply it yet.
  function automatic int m_fwd(bit [4:0] src);
    if (src == 0) return 0;
    for (int s = 0; s < 2; s++) begin
      if (pipe[s].wr && pipe[s].dst == src) begin
        if (s == 0 && !pipe[s].ld) return 1;
        if (s == 1) return pipe[s].ld ? 3 : 2;
      end
    end
    return 0;
  endfunction

  function automatic bit m_lu();
    bit hit_rs, hit_rt;
    hit_rs = id_use_rs && id_rs != 0 && id_rs == pipe[0].dst;
    hit_rt = id_use_rt && id_rt != 0 && id_rt == pipe[0].dst;
    return pipe[0].wr && pipe[0].ld && (hit_rs || hit_rt);
  endfunction

  function automatic bit m_mw();
    return pipe[1].acc && !mem_ready;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input bit [4:0] rs, input bit [4:0] rt, input bit urs, input bit urt,
                        input bit wr, input bit ld, input bit acc, input bit [4:0] rn,
                        input bit br);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wreg = wr; id_m2reg = ld; id_mem = acc; id_rn = rn; id_branch = br;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_ready = 1'b1;
    resetn    = 1'b1;
  endtask

  // Inputs are already driven; check against model, then let the rising edge happen.
  task automatic cyc();
    bit lu, mw;
    instr_t id_i;
    #1;
    lu = m_lu();
    mw = m_mw();
    chk("fwda",     16'(fwda),     16'(m_fwd(id_rs)));
    chk("fwdb",     16'(fwdb),     16'(m_fwd(id_rt)));
    chk("freeze",   16'(freeze),   16'(mw));
    chk("wpcir",    16'(wpcir),    16'(!lu && !mw));
    chk("bubble",   16'(bubble),   16'(lu && !mw));
    chk("flush_if", 16'(flush_if), 16'(id_branch && !lu && !mw));
    chk("state",    16'(state),    16'(m_state));
`ifdef PIPE_HAZARD_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 16'(m_cnt));
`endif
    @(posedge clock);
    if (!resetn) begin
      pipe[0] = nop(); pipe[1] = nop(); m_state = 0; m_cnt = 0;
    end else begin
      if (lu || mw) m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
      m_state = mw ? 2 : (lu ? 1 : 0);
      if (!mw) begin
        id_i.wr = id_wreg; id_i.ld = id_m2reg; id_i.acc = id_mem; id_i.dst = id_rn;
        pipe[1] = pipe[0];
        pipe[0] = lu ? nop() : id_i;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    pipe[0] = nop(); pipe[1] = nop(); m_state = 0; m_cnt = 0;
    idle();
    resetn = 1'b0;
    @(posedge clock);
    @(negedge clock);
    cyc();
    #1;
    chk("rst_wpcir", 16'(wpcir), 16'd1);
    chk("rst_fwda",  16'(fwda),  16'd0);
    resetn = 1'b1;
    cyc();

    // add r3 then dependent add: forward from EX, no stall
    set_id(1, 2, 1, 1, 1, 0, 0, 3, 0); cyc();
    set_id(3, 4, 1, 1, 1, 0, 0, 8, 0); #1;
    chk("alu_fwda", 16'(fwda), 16'd1);
    chk("alu_wpcir", 16'(wpcir), 16'd1);
    cyc();
    chk("alu_state", 16'(state), 16'd0);

    // lw r5 then add r6,r5,r7: one bubble, then load data from MEM
    set_id(1, 0, 1, 0, 1, 1, 1, 5, 0); cyc();
    set_id(5, 7, 1, 1, 1, 0, 0, 6, 0); #1;
    chk("lu_wpcir", 16'(wpcir), 16'd0);
    chk("lu_bubble", 16'(bubble), 16'd1);
    cyc();
    #1;
    chk("lu_state", 16'(state), 16'd1);
    chk("lu_fwda", 16'(fwda), 16'd3);
    chk("lu_wpcir2", 16'(wpcir), 16'd1);
    cyc();

    // back-to-back dependent loads each cost one bubble
    set_id(0, 0, 0, 0, 1, 1, 1, 9, 0); cyc();
    set_id(9, 0, 1, 0, 1, 1, 1, 10, 0); cyc();
    cyc();
    set_id(10, 0, 1, 0, 1, 0, 0, 11, 0); cyc();
    cyc();
    idle(); cyc(); cyc();

    // lw reaches MEM and waits three cycles, then completes
    set_id(0, 0, 0, 0, 1, 1, 1, 4, 0); cyc();
    idle(); cyc();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_freeze", 16'(freeze), 16'd1);
      chk("mw_wpcir", 16'(wpcir), 16'd0);
      cyc();
    end
    chk("mw_state", 16'(state), 16'd2);
    mem_ready = 1'b1; #1;
    chk("mw_release", 16'(freeze), 16'd0);
    cyc();
    chk("mw_run", 16'(state), 16'd0);
    idle(); cyc();

    // branch behind a load-use stall flushes only when it advances
    set_id(0, 0, 0, 0, 1, 1, 1, 12, 0); cyc();
    set_id(12, 0, 1, 0, 0, 0, 0, 0, 1); #1;
    chk("br_stall_flush", 16'(flush_if), 16'd0);
    cyc();
    #1;
    chk("br_go_flush", 16'(flush_if), 16'd1);
    cyc();
    idle(); cyc();

    // writes to r0 never forward or stall
    set_id(0, 0, 0, 0, 1, 0, 0, 0, 0); cyc();
    set_id(0, 0, 0, 0, 1, 1, 1, 0, 0); cyc();
    set_id(0, 0, 1, 1, 0, 0, 0, 0, 0); #1;
    chk("r0_fwda", 16'(fwda), 16'd0);
    chk("r0_wpcir", 16'(wpcir), 16'd1);
    cyc();
    idle(); cyc(); cyc();

    // reset in the middle of a memory wait
    set_id(0, 0, 0, 0, 1, 1, 1, 7, 0); cyc();
    idle(); cyc();
    mem_ready = 1'b0; cyc(); cyc();
    resetn = 1'b0; cyc();
    idle(); #1;
    chk("rst_mw_state", 16'(state), 16'd0);
    chk("rst_mw_freeze", 16'(freeze), 16'd0);
`ifdef PIPE_HAZARD_STALL_CNT_EN
    chk("rst_mw_cnt", stall_cnt, 16'd0);
`endif
    cyc();

    // random traffic with a narrow register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      id_rs     = 5'($urandom_range(0, 3));
      id_rt     = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom);
      id_use_rt = 1'($urandom);
      id_wreg   = 1'($urandom);
      id_m2reg  = 1'($urandom);
      id_mem    = 1'($urandom);
      id_rn     = 5'($urandom_range(0, 3));
      id_branch = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      resetn    = ($urandom_range(0, 63) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
